reg_file_dumper: RTL and testbench

REG_FILE_DUMPER -- requirements
Module: reg_file_dumper

---
 rtl/reg_file_dumper_pkg.sv | 17 +
 rtl/word_serializer.sv | 52 +++++
 rtl/reg_file_dumper.sv | 110 +++++++++++
 tb/tb_reg_file_dumper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_dumper_pkg.sv
// Shared FSM state type and header constant for reg_file_dumper.
// The HEADER state exists only when REG_FILE_DUMPER_HEADER_EN is defined.
package reg_file_dumper_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SEND   = 3'd2,
        DONE   = 3'd3
`ifdef REG_FILE_DUMPER_HEADER_EN
        , HEADER = 3'd4
`endif
    } dump_state_t;

    localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/word_serializer.sv
// Word shift register, byte counter and valid/ready output stage.
// Emits the captured word MSB-first, one NB_BYTE slice per accepted transfer.
module word_serializer
    import reg_file_dumper_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_load_hdr,
    input  logic               i_send,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last_xfer
);

    localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT        = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_WORD_BYTES - 1);

    logic [NB_DATA-1:0] shreg_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               xfer;

    assign o_tx_valid  = i_send;
    assign o_tx_data   = shreg_q[NB_DATA-1 -: NB_BYTE];
    assign xfer        = i_send & i_tx_ready;
    assign o_last_xfer = xfer & (cnt_q == LAST_BYTE);

    // A header load presets the counter to the last slot so a single transfer completes it.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (i_load) begin
            shreg_q <= i_word;
            cnt_q   <= '0;
        end else if (i_load_hdr) begin
            shreg_q                        <= '0;
            shreg_q[NB_DATA-1 -: NB_BYTE]  <= NB_BYTE'(DUMP_HEADER_BYTE);
            cnt_q                          <= LAST_BYTE;
        end else if (xfer) begin
            shreg_q <= shreg_q << NB_BYTE;
            cnt_q   <= (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_dumper.sv
// Streams every register of a register file out as bytes over a valid/ready link.
// Optional leading 0xA5 header byte when REG_FILE_DUMPER_HEADER_EN is defined.
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_REG = '1;

    dump_state_t        state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic               load, load_hdr, send, last_xfer;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        o_busy   = 1'b1;
        o_done   = 1'b0;
        load     = 1'b0;
        load_hdr = 1'b0;
        send     = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                idx_d  = '0;
                if (i_start) begin
`ifdef REG_FILE_DUMPER_HEADER_EN
                    load_hdr = 1'b1;
                    state_d  = HEADER;
`else
                    state_d  = LATCH;
`endif
                end
            end
`ifdef REG_FILE_DUMPER_HEADER_EN
            HEADER: begin
                send = 1'b1;
                if (last_xfer) state_d = LATCH;
            end
`endif
            LATCH: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                send = 1'b1;
                if (last_xfer) begin
                    if (idx_q == LAST_REG) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LATCH;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign o_rd_addr = idx_q;

    word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_load      (load),
        .i_word      (i_rd_data),
        .i_load_hdr  (load_hdr),
        .i_send      (send),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_last_xfer (last_xfer)
    );

endmodule

// File: tb/tb_reg_file_dumper.sv
// Scoreboard bench for reg_file_dumper: expected bytes are queued at i_start and
// popped on every accepted transfer. Honors REG_FILE_DUMPER_HEADER_EN.
module tb_reg_file_dumper;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_BYTE = 8;
    localparam int NREG    = 32;
    localparam int WB      = 4;
`ifdef REG_FILE_DUMPER_HEADER_EN
    localparam int NB_STREAM = NREG * WB + 1;
`else
    localparam int NB_STREAM = NREG * WB;
`endif

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_start = 1'b0;
    logic [NB_ADDR-1:0] o_rd_addr;
    logic [NB_DATA-1:0] i_rd_data;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready = 1'b1;
    logic               o_busy;
    logic               o_done;

    logic [NB_DATA-1:0] mem [NREG];
    assign i_rd_data = mem[o_rd_addr];

    always #5 clk = ~clk;

    reg_file_dumper #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .NB_BYTE (NB_BYTE)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    logic [7:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;
    int n_bytes = 0;
    int n_done  = 0;
    bit ready_toggle = 1'b0;
    bit hold_pending = 1'b0;
    logic [7:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transfers are judged at the negedge preceding the accepting posedge.
    always @(negedge clk) begin
        if (o_tx_valid && hold_pending) check("hold", o_tx_data, held);
        hold_pending = 1'b0;
        if (!i_reset && o_tx_valid && i_tx_ready) begin
            check("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte", o_tx_data, exp_q.pop_front());
            n_bytes++;
        end else if (!i_reset && o_tx_valid) begin
            held         = o_tx_data;
            hold_pending = 1'b1;
        end
        if (!i_reset && o_done) begin
            check("done_busy", o_busy, 1);
            n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_toggle) i_tx_ready = ~i_tx_ready;
    endtask

    task automatic init_mem();
        for (int i = 0; i < NREG; i++) mem[i] = 32'h0100_0000 * i + i;
    endtask

    task automatic push_expected();
`ifdef REG_FILE_DUMPER_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 0; i < NREG; i++)
            for (int b = WB - 1; b >= 0; b--) exp_q.push_back(mem[i][b*8 +: 8]);
    endtask

    task automatic run_dump(input string tag, input int start_at, input int reset_at,
                            input bit r3_write);
        int  b0, d0, cyc;
        bit  pulsed, aborted, write_next;
        b0 = n_bytes; d0 = n_done; cyc = 0;
        pulsed = 1'b0; aborted = 1'b0; write_next = 1'b0;
        push_expected();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        while (n_done == d0 && cyc < 5000 && !aborted) begin
            if (start_at >= 0 && !pulsed && n_bytes - b0 == start_at) begin
                i_start = 1'b1;
                pulsed  = 1'b1;
            end
            if (reset_at >= 0 && n_bytes - b0 == reset_at) begin
                i_reset = 1'b1;
                aborted = 1'b1;
            end
            if (r3_write && o_busy && !o_tx_valid && o_rd_addr == 5'd3) write_next = 1'b1;
            tick();
            i_start = 1'b0;
            if (write_next) begin
                mem[3]     = 32'hDEAD_BEEF;
                write_next = 1'b0;
            end
            cyc++;
        end
        if (aborted) begin
            check({tag, "_rst_valid"}, o_tx_valid, 0);
            check({tag, "_rst_busy"}, o_busy, 0);
            check({tag, "_rst_addr"}, o_rd_addr, 0);
            check({tag, "_rst_data"}, o_tx_data, 0);
            i_reset = 1'b0;
            exp_q.delete();
            repeat (10) tick();
            check({tag, "_rst_bytes"}, n_bytes - b0, reset_at);
            check({tag, "_rst_nodone"}, n_done - d0, 0);
            check({tag, "_rst_idle_valid"}, o_tx_valid, 0);
        end else begin
            check({tag, "_done_seen"}, n_done - d0, 1);
            repeat (5) tick();
            check({tag, "_one_done"}, n_done - d0, 1);
            check({tag, "_bytes"}, n_bytes - b0, NB_STREAM);
            check({tag, "_q_empty"}, exp_q.size(), 0);
            check({tag, "_idle_busy"}, o_busy, 0);
            check({tag, "_idle_addr"}, o_rd_addr, 0);
        end
    endtask

    initial begin
        init_mem();
        repeat (3) tick();
        check("reset_valid", o_tx_valid, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_addr", o_rd_addr, 0);
        check("reset_data", o_tx_data, 0);
        i_start = 1'b1;
        tick();
        check("reset_over_start", o_busy, 0);
        i_start = 1'b0;
        i_reset = 1'b0;
        repeat (2) tick();

        run_dump("basic", -1, -1, 1'b0);

        ready_toggle = 1'b1;
        run_dump("toggle", -1, -1, 1'b0);
        ready_toggle = 1'b0;
        i_tx_ready   = 1'b1;

        run_dump("restart_ign", 50, -1, 1'b0);

        run_dump("abort", -1, 70, 1'b0);
        run_dump("after_abort", -1, -1, 1'b0);

        mem[3] = 32'h0;
        run_dump("r3_write", -1, -1, 1'b1);
        init_mem();

        ready_toggle = 1'b1;
        run_dump("toggle2", -1, -1, 1'b0);
        ready_toggle = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
